// File: rtl/shot_tracer_pkg.sv
// Shared geometry, colours and state encoding for the shot tracer and gun sprite.
package shot_tracer_pkg;

  // Visible screen size; coordinate buses are wide enough for the larger axis.
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned PIX_W    = $clog2((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H);

  // Gun barrel footprint relative to the gun's left edge, and its top row.
  localparam int unsigned BARREL_X0 = 26;
  localparam int unsigned BARREL_X1 = 36;
  localparam int unsigned BARREL_Y  = 434;

  // Horizontal growth of the impact flash on each side of the bullet.
  localparam int unsigned FLASH_PAD = 2;

  localparam int unsigned COLOR_W = 6;
  localparam logic [COLOR_W-1:0] DEF_BULLET_COLOR = 6'h3F;
  localparam logic [COLOR_W-1:0] DEF_FLASH_COLOR  = 6'h30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLY   = 2'd1,
    ST_FLASH = 2'd2
  } state_e;

  // Zero-extend a coordinate by one bit so sums of coordinates cannot wrap.
  function automatic logic [PIX_W:0] ext(input logic [PIX_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/shot_tracer_if.sv
// Pixel, gun and duck signals exchanged between the shot tracer and the rest of the game.
interface shot_tracer_if;
  import shot_tracer_pkg::*;

  logic [PIX_W-1:0]   hcount;
  logic [PIX_W-1:0]   vcount;
  logic               fire;
  logic [PIX_W-1:0]   gun_offset;
  logic [PIX_W-1:0]   duck_x;
  logic [PIX_W-1:0]   duck_y;
  logic               duck_valid;
  logic [COLOR_W-1:0] data;
  logic               draw;
  logic               hit;
  logic               busy;

  modport master (
    output hcount, vcount, fire, gun_offset, duck_x, duck_y, duck_valid,
    input  data, draw, hit, busy
  );

  modport slave (
    input  hcount, vcount, fire, gun_offset, duck_x, duck_y, duck_valid,
    output data, draw, hit, busy
  );

endinterface

// File: rtl/shot_tracer_tick_divider.sv
// Movement tick generator: counts 0..DIV-1 and pulses tick for one cycle on the wrap.
module tick_divider #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear restarts the period, otherwise wrap at LAST.
  always_comb begin
    tick  = (cnt_q == LAST) && !clear;
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shot_tracer.sv
// Bullet launched from the gun barrel, moved upward on ticks, tested against the duck box,
// with a one-cycle hit pulse and a short impact flash drawn at the frozen bullet position.
module shot_tracer
  import shot_tracer_pkg::*;
#(
  parameter int unsigned STEP_DIV    = 50000,
  parameter int unsigned STEP_PX     = 2,
  parameter int unsigned BULLET_W    = 4,
  parameter int unsigned BULLET_H    = 8,
  parameter int unsigned DUCK_W      = 32,
  parameter int unsigned DUCK_H      = 32,
  parameter int unsigned FLASH_TICKS = 16,
  parameter logic [COLOR_W-1:0] BULLET_COLOR = DEF_BULLET_COLOR,
  parameter logic [COLOR_W-1:0] FLASH_COLOR  = DEF_FLASH_COLOR
) (
  input  logic         clk,
  input  logic         reset,
  shot_tracer_if.slave bus
);
  localparam int unsigned CW       = PIX_W + 1;
  // Bullet centred on the barrel: columns 29..32 of the 26..36 barrel for a 4 px bullet.
  localparam int unsigned BX_OFS   = (BARREL_X0 + BARREL_X1) / 2 - BULLET_W / 2;
  localparam int unsigned BY_START = BARREL_Y - BULLET_H;
  localparam int unsigned FC_W     = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLASH_TICKS - 1);

  state_e             state_q, state_d;
  logic               fire_q;
  logic [PIX_W-1:0]   bx_q, bx_d, by_q, by_d;
  logic [FC_W-1:0]    flash_cnt_q, flash_cnt_d;
  logic               hit_q, hit_d;
  logic               draw_q, draw_d;
  logic [COLOR_W-1:0] data_q, data_d;

  logic               fire_edge, launch, tick, miss, collide;
  logic [PIX_W-1:0]   by_step;
  logic [PIX_W:0]     x_lo, x_hi, y_lo, y_hi;
  logic [COLOR_W-1:0] color;
  logic               in_rect;

  // Box overlap in one-bit-wider arithmetic so right/bottom edges never wrap.
  function automatic logic overlaps(input logic [PIX_W-1:0] x, input logic [PIX_W-1:0] y,
                                    input logic [PIX_W-1:0] dx, input logic [PIX_W-1:0] dy);
    return (ext(x) <= ext(dx) + CW'(DUCK_W - 1)) &&
           (ext(dx) <= ext(x) + CW'(BULLET_W - 1)) &&
           (ext(y) <= ext(dy) + CW'(DUCK_H - 1)) &&
           (ext(dy) <= ext(y) + CW'(BULLET_H - 1));
  endfunction

  assign fire_edge = bus.fire && !fire_q;
  assign launch    = (state_q == ST_IDLE) && fire_edge;
  // The miss check uses the pre-move position, the overlap test the moved one.
  assign miss      = ext(by_q) < CW'(STEP_PX);
  assign by_step   = by_q - PIX_W'(STEP_PX);
  assign collide   = bus.duck_valid && overlaps(bx_q, by_step, bus.duck_x, bus.duck_y);

  tick_divider #(
    .DIV (STEP_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (launch),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: launch on a fire edge, end flight on miss or hit, end flash after its ticks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fire_edge) begin
          state_d = ST_FLY;
        end
      end
      ST_FLY: begin
        if (tick) begin
          if (miss) begin
            state_d = ST_IDLE;
          end else if (collide) begin
            state_d = ST_FLASH;
          end
        end
      end
      ST_FLASH: begin
        if (tick && (flash_cnt_q == FC_LAST)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: hit pulse and the bullet/flash rectangle for the pixel being scanned.
  always_comb begin
    hit_d = (state_q == ST_FLY) && tick && !miss && collide;
    x_lo  = ext(bx_q);
    x_hi  = ext(bx_q) + CW'(BULLET_W - 1);
    y_lo  = ext(by_q);
    y_hi  = ext(by_q) + CW'(BULLET_H - 1);
    color = BULLET_COLOR;
    // Flash widens horizontally only; the left edge clamps at column 0.
    if (state_q == ST_FLASH) begin
      x_lo  = (ext(bx_q) >= CW'(FLASH_PAD)) ? (ext(bx_q) - CW'(FLASH_PAD)) : '0;
      x_hi  = x_hi + CW'(FLASH_PAD);
      color = FLASH_COLOR;
    end
    in_rect = (ext(bus.hcount) >= x_lo) && (ext(bus.hcount) <= x_hi) &&
              (ext(bus.vcount) >= y_lo) && (ext(bus.vcount) <= y_hi);
    draw_d  = (state_q != ST_IDLE) && in_rect;
    data_d  = draw_d ? color : data_q;
  end

  // Position and flash counter: position latched at launch, frozen once the flash starts.
  always_comb begin
    bx_d        = bx_q;
    by_d        = by_q;
    flash_cnt_d = flash_cnt_q;
    if (launch) begin
      bx_d = bus.gun_offset + PIX_W'(BX_OFS);
      by_d = PIX_W'(BY_START);
    end else if ((state_q == ST_FLY) && tick && !miss) begin
      by_d = by_step;
    end
    if (hit_d) begin
      flash_cnt_d = '0;
    end else if ((state_q == ST_FLASH) && tick) begin
      flash_cnt_d = flash_cnt_q + 1'b1;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fire_q      <= 1'b0;
      flash_cnt_q <= '0;
      hit_q       <= 1'b0;
      draw_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      fire_q      <= bus.fire;
      flash_cnt_q <= flash_cnt_d;
      hit_q       <= hit_d;
      draw_q      <= draw_d;
      data_q      <= data_d;
    end
  end

  // Bullet position registers; only meaningful while not idle.
  always_ff @(posedge clk) begin
    bx_q <= bx_d;
    by_q <= by_d;
  end

  assign bus.hit  = hit_q;
  assign bus.draw = draw_q;
  assign bus.data = data_q;
  assign bus.busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shot_tracer.sv
// Directed bench for shot_tracer with a fast movement tick (STEP_DIV = 4).
module tb_shot_tracer;
  import shot_tracer_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  shot_tracer_if bus();

  shot_tracer #(.STEP_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         go;
    int         k;
    int         h;
    int         v;
    logic       exp_draw;
    logic [5:0] exp_data;
  } vec_t;

  typedef struct {
    int         h;
    int         v;
    logic       exp_draw;
    logic [5:0] exp_data;
  } probe_t;

  vec_t   vecs[15];
  probe_t flash_probes[7];

  int applied     = 0;
  int miscompares = 0;
  int n           = 0;
  int hits        = 0;
  int last_hit_n  = -1;

  task automatic chk(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    #1;
    n++;
    if (bus.hit) begin
      hits++;
      last_hit_n = n;
    end
  endtask

  task automatic run_to(input int target);
    while (n < target) cyc1();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.fire = 1'b0;
    cyc1();
    cyc1();
    reset = 1'b0;
    cyc1();
    hits       = 0;
    last_hit_n = -1;
  endtask

  task automatic set_duck(input int x, input int y, input logic vld);
    bus.duck_x     = 10'(x);
    bus.duck_y     = 10'(y);
    bus.duck_valid = vld;
  endtask

  task automatic set_pix(input int h, input int v);
    bus.hcount = 10'(h);
    bus.vcount = 10'(v);
  endtask

  // Launch with a fire edge on the next clock; the sample after that edge is n = 0.
  task automatic launch(input int go);
    bus.gun_offset = 10'(go);
    bus.fire       = 1'b1;
    n              = -1;
  endtask

  initial begin
    int rises;
    int exit_n;
    int rowdraws;
    int first_row;
    logic prevb;

    bus.fire = 1'b0;
    set_pix(0, 0);
    bus.gun_offset = '0;
    set_duck(0, 0, 1'b0);

    vecs[0]  = '{100, 1, 129, 426, 1'b1, 6'h3F};
    vecs[1]  = '{100, 1, 133, 426, 1'b0, 6'h00};
    vecs[2]  = '{100, 1, 132, 433, 1'b1, 6'h3F};
    vecs[3]  = '{100, 1, 128, 426, 1'b0, 6'h00};
    vecs[4]  = '{100, 1, 129, 425, 1'b0, 6'h00};
    vecs[5]  = '{100, 1, 129, 434, 1'b0, 6'h00};
    vecs[6]  = '{  0, 1,  29, 426, 1'b1, 6'h3F};
    vecs[7]  = '{  0, 1,  33, 430, 1'b0, 6'h00};
    vecs[8]  = '{578, 1, 607, 430, 1'b1, 6'h3F};
    vecs[9]  = '{578, 1, 611, 430, 1'b0, 6'h00};
    vecs[10] = '{578, 1, 610, 433, 1'b1, 6'h3F};
    vecs[11] = '{100, 4, 129, 433, 1'b1, 6'h3F};
    vecs[12] = '{100, 5, 129, 432, 1'b0, 6'h3F};
    vecs[13] = '{100, 5, 129, 424, 1'b1, 6'h3F};
    vecs[14] = '{100, 0, 129, 426, 1'b0, 6'h00};

    flash_probes[0] = '{127, 410, 1'b1, 6'h30};
    flash_probes[1] = '{126, 410, 1'b0, 6'h30};
    flash_probes[2] = '{134, 410, 1'b1, 6'h30};
    flash_probes[3] = '{135, 410, 1'b0, 6'h30};
    flash_probes[4] = '{129, 417, 1'b1, 6'h30};
    flash_probes[5] = '{129, 418, 1'b0, 6'h30};
    flash_probes[6] = '{130, 409, 1'b0, 6'h30};

    // Reset state
    cyc1();
    cyc1();
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_draw", int'(bus.draw), 0);
    chk("reset_hit",  int'(bus.hit),  0);
    chk("reset_data", int'(bus.data), 0);
    reset = 1'b0;
    cyc1();

    // Launch geometry and draw latency
    foreach (vecs[i]) begin
      do_reset();
      set_pix(vecs[i].h, vecs[i].v);
      launch(vecs[i].go);
      run_to(vecs[i].k);
      chk($sformatf("vec%0d_draw", i), int'(bus.draw), int'(vecs[i].exp_draw));
      chk($sformatf("vec%0d_data", i), int'(bus.data), int'(vecs[i].exp_data));
      bus.fire = 1'b0;
    end

    // busy one cycle after the fire edge; data holds when draw drops
    do_reset();
    set_pix(0, 0);
    bus.gun_offset = 10'd100;
    chk("busy_before_edge", int'(bus.busy), 0);
    launch(100);
    cyc1();
    chk("busy_after_edge", int'(bus.busy), 1);
    set_pix(129, 426);
    cyc1();
    chk("hold_draw_on", int'(bus.draw), 1);
    set_pix(0, 0);
    cyc1();
    chk("hold_draw_off", int'(bus.draw), 0);
    chk("hold_data", int'(bus.data), 'h3F);

    // Duck present but not valid: bullet reaches row 0, then leaves at the top
    do_reset();
    set_duck(120, 380, 1'b0);
    set_pix(129, 0);
    launch(100);
    exit_n    = -1;
    rowdraws  = 0;
    first_row = -1;
    while (n < 2000 && exit_n < 0) begin
      cyc1();
      if (bus.draw) begin
        rowdraws++;
        if (first_row < 0) first_row = n;
      end
      if (!bus.busy) exit_n = n;
    end
    chk("miss_exit_cycle", exit_n, 856);
    chk("miss_row0_first", first_row, 853);
    chk("miss_row0_cycles", rowdraws, 4);
    chk("miss_no_hit", hits, 0);

    // Hit at by = 410, flash widened to columns 127..134, idle after 16 ticks
    do_reset();
    set_duck(120, 380, 1'b1);
    set_pix(0, 0);
    launch(100);
    while (hits == 0 && n < 200) cyc1();
    chk("hit_cycle", last_hit_n, 32);
    bus.fire = 1'b0;
    foreach (flash_probes[i]) begin
      set_pix(flash_probes[i].h, flash_probes[i].v);
      cyc1();
      chk($sformatf("flash%0d_draw", i), int'(bus.draw), int'(flash_probes[i].exp_draw));
      chk($sformatf("flash%0d_data", i), int'(bus.data), int'(flash_probes[i].exp_data));
    end
    chk("flash_busy", int'(bus.busy), 1);
    while (bus.busy && n < 300) cyc1();
    chk("flash_exit_cycle", n, 96);
    run_to(110);
    chk("hit_single_pulse", hits, 1);

    // Reset during flash, with a fire edge in the reset cycle
    do_reset();
    set_duck(120, 380, 1'b1);
    set_pix(129, 410);
    launch(100);
    while (hits == 0 && n < 200) cyc1();
    bus.fire = 1'b0;
    run_to(40);
    chk("pre_reset_flash_draw", int'(bus.draw), 1);
    reset    = 1'b1;
    bus.fire = 1'b1;
    cyc1();
    chk("rst_flash_busy", int'(bus.busy), 0);
    chk("rst_flash_draw", int'(bus.draw), 0);
    chk("rst_flash_hit",  int'(bus.hit),  0);
    reset    = 1'b0;
    bus.fire = 1'b0;
    cyc1();
    cyc1();
    cyc1();
    chk("rst_flash_no_launch", int'(bus.busy), 0);
    chk("rst_flash_hits", hits, 1);

    // Reset together with a fire edge while idle
    reset    = 1'b1;
    bus.fire = 1'b1;
    cyc1();
    chk("rst_fire_busy", int'(bus.busy), 0);
    reset    = 1'b0;
    bus.fire = 1'b0;
    cyc1();
    chk("rst_fire_busy_after", int'(bus.busy), 0);

    // duck_valid drops mid-flight: no hit
    do_reset();
    set_duck(120, 380, 1'b1);
    set_pix(0, 0);
    launch(100);
    run_to(20);
    bus.duck_valid = 1'b0;
    run_to(60);
    chk("valid_drop_no_hit", hits, 0);
    chk("valid_drop_still_flying", int'(bus.busy), 1);

    // fire held for 1000 cycles: exactly one launch
    do_reset();
    set_duck(120, 380, 1'b0);
    launch(100);
    rises = 0;
    prevb = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      cyc1();
      if (bus.busy && !prevb) rises++;
      prevb = bus.busy;
    end
    chk("hold_fire_launches", rises, 1);
    chk("hold_fire_idle_end", int'(bus.busy), 0);

    // Second fire edge during flight does not relaunch
    do_reset();
    set_pix(0, 0);
    launch(100);
    run_to(10);
    bus.fire = 1'b0;
    run_to(12);
    bus.fire = 1'b1;
    run_to(20);
    set_pix(129, 416);
    cyc1();
    chk("refire_row416", int'(bus.draw), 1);
    set_pix(129, 424);
    cyc1();
    chk("refire_row424", int'(bus.draw), 0);
    chk("refire_busy", int'(bus.busy), 1);
    bus.fire = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
